// File: rtl/spike_detector_param.sv
// Sliding-window mean tracker with |x - mean| spike detection, fixed or MAD-adaptive
// threshold, refractory suppression and a saturating spike counter.
module spike_detector_param #(
  parameter int DATA_W      = 16,
  parameter int LOG2_WIN    = 7,
  parameter int THR_MODE    = 0,
  parameter int K_SHIFT     = 2,
  parameter int ALPHA_SHIFT = 4,
  parameter int MAD_INIT    = 256,
  parameter int REFRACT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W:0]   thr_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] mean_out,
  output logic [DATA_W:0]   dev_out,
  output logic              spike_detected,
  output logic              trained,
  output logic [15:0]       spike_count,
  output logic              dbg_state
);

  // Handshake: in_valid qualifies data_in/thr_in for exactly one cycle; there is no
  // backpressure. out_valid pulses one cycle after each OPERATE sample is accepted.

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam int DEV_W = DATA_W + 1;
  localparam int SH_W  = DEV_W + K_SHIFT;
  localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;
  localparam logic [DEV_W-1:0]    DEV_MAX  = '1;

  typedef enum logic {
    S_TRAIN   = 1'b0,
    S_OPERATE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_W-1:0]        r_buf [WIN];
  logic signed [SUM_W-1:0]  r_sum;
  logic [LOG2_WIN-1:0]      r_idx;
  logic [LOG2_WIN-1:0]      r_sample_cnt;
  logic signed [DATA_W-1:0] r_mean;
  logic [DEV_W-1:0]         r_mad;
  logic [RC_W-1:0]          r_refr;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_mean_out;
  logic [DEV_W-1:0]  r_dev_out;
  logic              r_spike;
  logic              r_trained;
  logic [15:0]       r_spike_count;

  logic signed [SUM_W-1:0]  w_x_ext;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_sum_train;
  logic signed [SUM_W-1:0]  w_sum_op;
  logic signed [SUM_W-1:0]  w_sum_sel;
  logic signed [DATA_W-1:0] w_mean_new;
  logic signed [DATA_W+1:0] w_diff;
  logic [DEV_W-1:0]         w_dev;
  logic [SH_W-1:0]          w_mad_wide;
  logic [DEV_W-1:0]         w_thr_adapt;
  logic [DEV_W-1:0]         w_thr;
  logic                     w_hit;
  logic                     w_spike;
  logic signed [DEV_W+1:0]  w_mad_diff;
  logic signed [DEV_W+1:0]  w_mad_step;
  logic [DEV_W-1:0]         w_mad_new;
  logic                     w_train_done;
  logic                     w_buf_we;
  logic [LOG2_WIN-1:0]      w_buf_addr;

  // The window sum is wide enough for WIN full-scale samples, so the running
  // add/subtract never overflows even if intermediate terms wrap.
  always_comb begin
    w_x_ext     = {{LOG2_WIN{data_in[DATA_W-1]}}, data_in};
    w_old_ext   = {{LOG2_WIN{r_buf[r_idx][DATA_W-1]}}, r_buf[r_idx]};
    w_sum_train = r_sum + w_x_ext;
    w_sum_op    = r_sum - w_old_ext + w_x_ext;
    w_sum_sel   = (r_state == S_TRAIN) ? w_sum_train : w_sum_op;
    w_mean_new  = DATA_W'(w_sum_sel >>> LOG2_WIN);
  end

  // Deviation against the mean registered before this sample; two guard bits keep
  // the full-scale difference from wrapping.
  always_comb begin
    w_diff = {{2{data_in[DATA_W-1]}}, data_in} - {{2{r_mean[DATA_W-1]}}, r_mean};
    w_dev  = w_diff[DATA_W+1] ? DEV_W'(-w_diff) : DEV_W'(w_diff);
  end

  always_comb begin
    w_mad_wide  = SH_W'(r_mad) << K_SHIFT;
    w_thr_adapt = (w_mad_wide > SH_W'(DEV_MAX)) ? DEV_MAX : DEV_W'(w_mad_wide);
    w_thr       = (THR_MODE == 1) ? w_thr_adapt : thr_in;
    w_hit       = (w_dev > w_thr);
    w_spike     = w_hit && (r_refr == '0);
  end

  // EMA step uses a signed difference with floor shift so the tracker can fall as well as rise.
  always_comb begin
    w_mad_diff = $signed({2'b00, w_dev}) - $signed({2'b00, r_mad});
    w_mad_step = w_mad_diff >>> ALPHA_SHIFT;
    w_mad_new  = DEV_W'($signed({2'b00, r_mad}) + w_mad_step);
  end

  always_comb begin
    w_next_state = r_state;
    w_train_done = 1'b0;
    w_buf_we     = 1'b0;
    w_buf_addr   = r_idx;
    case (r_state)
      S_TRAIN: begin
        w_buf_addr = r_sample_cnt;
        if (in_valid) begin
          w_buf_we = 1'b1;
          if (r_sample_cnt == CNT_LAST) begin
            w_train_done = 1'b1;
            w_next_state = S_OPERATE;
          end
        end
      end
      S_OPERATE: begin
        w_buf_we = in_valid;
      end
      default: w_next_state = S_TRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_TRAIN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Buffer contents are never read before TRAIN has overwritten them.
  always_ff @(posedge clk) begin
    if (w_buf_we && !rst) begin
      r_buf[w_buf_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum         <= '0;
      r_idx         <= '0;
      r_sample_cnt  <= '0;
      r_mean        <= '0;
      r_mad         <= DEV_W'(MAD_INIT);
      r_refr        <= '0;
      r_out_valid   <= 1'b0;
      r_mean_out    <= '0;
      r_dev_out     <= '0;
      r_spike       <= 1'b0;
      r_trained     <= 1'b0;
      r_spike_count <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_spike     <= 1'b0;
      if (in_valid && (r_state == S_TRAIN)) begin
        r_sum        <= w_sum_train;
        r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_train_done) begin
          r_mean     <= w_mean_new;
          r_mean_out <= w_mean_new;
          r_idx      <= '0;
          r_trained  <= 1'b1;
        end
      end else if (in_valid) begin
        r_sum       <= w_sum_op;
        r_idx       <= r_idx + 1'b1;
        r_mean      <= w_mean_new;
        r_mean_out  <= w_mean_new;
        r_dev_out   <= w_dev;
        r_spike     <= w_spike;
        r_out_valid <= 1'b1;
        if (w_spike) begin
          r_refr <= RC_W'(REFRACT);
          if (r_spike_count != 16'hFFFF) begin
            r_spike_count <= r_spike_count + 16'd1;
          end
        end else if (r_refr != '0) begin
          r_refr <= r_refr - RC_W'(1);
        end
        if (!w_hit) begin
          r_mad <= w_mad_new;
        end
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign mean_out       = r_mean_out;
  assign dev_out        = r_dev_out;
  assign spike_detected = r_spike;
  assign trained        = r_trained;
  assign spike_count    = r_spike_count;
  assign dbg_state      = (r_state == S_OPERATE);

endmodule
